// File: rtl/turf_acknack_merge.sv
// Merges the ACK and NACK acknack streams into one registered frame-buffer stream.
// Round-robin fairness, source-forced allow bit, duplicate suppression, and saturating statistics.
module turf_acknack_merge #(
   parameter int ADDR_BITS = 12,
   parameter int CNT_BITS  = 32,
   parameter int DROP_BITS = 16
) (
   input  logic                 aclk,
   input  logic                 aresetn,
   input  logic                 event_open_i,
   input  logic [15:0]          s_ack_tdata,
   input  logic                 s_ack_tvalid,
   output logic                 s_ack_tready,
   input  logic [15:0]          s_nack_tdata,
   input  logic                 s_nack_tvalid,
   output logic                 s_nack_tready,
   output logic [15:0]          m_fb_tdata,
   output logic                 m_fb_tvalid,
   input  logic                 m_fb_tready,
   output logic [CNT_BITS-1:0]  ack_count_o,
   output logic [CNT_BITS-1:0]  nack_count_o,
   output logic [DROP_BITS-1:0] drop_count_o
);

   localparam logic GRANT_ACK  = 1'b0;
   localparam logic GRANT_NACK = 1'b1;

   logic        m_valid_reg, m_valid_next;
   logic [15:0] m_data_reg, m_data_next;
   logic        last_grant_reg, last_grant_next;
   logic        last_fwd_valid_reg, last_fwd_valid_next;
   logic [15:0] last_fwd_reg, last_fwd_next;
   logic [DROP_BITS-1:0] drop_reg;

   logic        load;
   logic        grant_ack, grant_nack;
   logic        accept;
   logic [15:0] sel_word;
   logic        dup;
   logic [1:0]  fwd_inc;
   logic        drop_inc;

   // Per-source formatting and forwarded-command statistics; index 0 is ACK, 1 is NACK.
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_src
         localparam logic ALLOW = (gi == 0);
         logic [15:0]         raw;
         logic [15:0]         word;
         logic                unused_hi;
         logic [CNT_BITS-1:0] cnt_reg;

         assign raw       = (gi == 0) ? s_ack_tdata : s_nack_tdata;
         assign word      = {ALLOW, 15'(raw[ADDR_BITS-1:0])};
         assign unused_hi = ^raw[15:ADDR_BITS];

         always_ff @(posedge aclk) begin
            if (!aresetn) begin
               cnt_reg <= '0;
            end else if (fwd_inc[gi] && (cnt_reg != {CNT_BITS{1'b1}})) begin
               cnt_reg <= cnt_reg + CNT_BITS'(1);
            end
         end
      end
   endgenerate

   assign load = !m_valid_reg || m_fb_tready;

   // On a tie the source that did not win last time gets the slot.
   assign grant_ack  = s_ack_tvalid && (!s_nack_tvalid || (last_grant_reg == GRANT_NACK));
   assign grant_nack = s_nack_tvalid && !grant_ack;

   assign s_ack_tready  = !event_open_i || (grant_ack && load);
   assign s_nack_tready = !event_open_i || (grant_nack && load);

   assign accept   = event_open_i && (grant_ack || grant_nack) && load;
   assign sel_word = grant_nack ? g_src[1].word : g_src[0].word;
   assign dup      = last_fwd_valid_reg && (sel_word == last_fwd_reg);

   always_comb begin
      m_valid_next        = m_valid_reg && !m_fb_tready;
      m_data_next         = m_data_reg;
      last_grant_next     = last_grant_reg;
      last_fwd_valid_next = last_fwd_valid_reg;
      last_fwd_next       = last_fwd_reg;
      fwd_inc             = 2'b00;
      drop_inc            = 1'b0;
      if (!event_open_i) begin
         last_fwd_valid_next = 1'b0;
      end else if (accept) begin
         last_grant_next = grant_nack;
         if (dup) begin
            drop_inc = 1'b1;
         end else begin
            m_data_next          = sel_word;
            m_valid_next         = 1'b1;
            last_fwd_next        = sel_word;
            last_fwd_valid_next  = 1'b1;
            fwd_inc[grant_nack]  = 1'b1;
         end
      end
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         m_valid_reg        <= 1'b0;
         m_data_reg         <= 16'h0000;
         last_grant_reg     <= GRANT_NACK;
         last_fwd_valid_reg <= 1'b0;
         last_fwd_reg       <= 16'h0000;
      end else begin
         m_valid_reg        <= m_valid_next;
         m_data_reg         <= m_data_next;
         last_grant_reg     <= last_grant_next;
         last_fwd_valid_reg <= last_fwd_valid_next;
         last_fwd_reg       <= last_fwd_next;
      end
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         drop_reg <= '0;
      end else if (drop_inc && (drop_reg != {DROP_BITS{1'b1}})) begin
         drop_reg <= drop_reg + DROP_BITS'(1);
      end
   end

   assign m_fb_tvalid  = m_valid_reg;
   assign m_fb_tdata   = m_data_reg;
   assign ack_count_o  = g_src[0].cnt_reg;
   assign nack_count_o = g_src[1].cnt_reg;
   assign drop_count_o = drop_reg;

endmodule

// File: tb/tb_turf_acknack_merge.sv
// Self-checking bench for turf_acknack_merge: directed scenarios plus randomized traffic
// compared against a transaction-level reference model.
module tb_turf_acknack_merge;

   localparam int AB = 12;
   localparam int CB = 4;
   localparam int DB = 4;
   localparam int CMAX = (1 << CB) - 1;
   localparam int DMAX = (1 << DB) - 1;

   logic          aclk = 1'b0;
   logic          aresetn;
   logic          event_open_i;
   logic [15:0]   s_ack_tdata, s_nack_tdata;
   logic          s_ack_tvalid, s_nack_tvalid;
   logic          s_ack_tready, s_nack_tready;
   logic [15:0]   m_fb_tdata;
   logic          m_fb_tvalid;
   logic          m_fb_tready;
   logic [CB-1:0] ack_count_o, nack_count_o;
   logic [DB-1:0] drop_count_o;

   int passed = 0;
   int total  = 0;

   // reference model state
   bit          m_mv;
   logic [15:0] m_md;
   int          m_lg;   // 0 = ACK won last, 1 = NACK won last
   bit          m_lfv;
   logic [15:0] m_lf;
   int          m_ack, m_nack, m_drop;

   always #5 aclk = ~aclk;

   turf_acknack_merge #(.ADDR_BITS(AB), .CNT_BITS(CB), .DROP_BITS(DB)) dut (
      .aclk(aclk), .aresetn(aresetn), .event_open_i(event_open_i),
      .s_ack_tdata(s_ack_tdata), .s_ack_tvalid(s_ack_tvalid), .s_ack_tready(s_ack_tready),
      .s_nack_tdata(s_nack_tdata), .s_nack_tvalid(s_nack_tvalid), .s_nack_tready(s_nack_tready),
      .m_fb_tdata(m_fb_tdata), .m_fb_tvalid(m_fb_tvalid), .m_fb_tready(m_fb_tready),
      .ack_count_o(ack_count_o), .nack_count_o(nack_count_o), .drop_count_o(drop_count_o)
   );

   function automatic int pick();
      if (!event_open_i) return -1;
      if (s_ack_tvalid && s_nack_tvalid) return (m_lg == 0) ? 1 : 0;
      if (s_ack_tvalid) return 0;
      if (s_nack_tvalid) return 1;
      return -1;
   endfunction

   function automatic bit exp_load();
      return !m_mv || m_fb_tready;
   endfunction

   task automatic model_step();
      int src;
      bit ld;
      logic [15:0] w;
      if (!aresetn) begin
         m_mv = 0; m_md = 16'h0; m_lg = 1; m_lfv = 0; m_lf = 16'h0;
         m_ack = 0; m_nack = 0; m_drop = 0;
         return;
      end
      src = pick();
      ld  = exp_load();
      if (m_mv && m_fb_tready) m_mv = 0;
      if (!event_open_i) begin
         m_lfv = 0;
         return;
      end
      if (src >= 0 && ld) begin
         w = ((src == 0) ? s_ack_tdata : s_nack_tdata) & 16'((1 << AB) - 1);
         if (src == 0) w = w | 16'h8000;
         m_lg = src;
         if (m_lfv && w == m_lf) begin
            if (m_drop < DMAX) m_drop++;
         end else begin
            m_md = w; m_mv = 1; m_lf = w; m_lfv = 1;
            if (src == 0 && m_ack < CMAX) m_ack++;
            if (src == 1 && m_nack < CMAX) m_nack++;
         end
      end
   endtask

   task automatic tick();
      model_step();
      @(posedge aclk);
      #1;
   endtask

   task automatic idle_inputs();
      s_ack_tvalid = 0; s_nack_tvalid = 0;
      s_ack_tdata = 16'h0; s_nack_tdata = 16'h0;
   endtask

   task automatic do_reset();
      aresetn = 0; event_open_i = 1; m_fb_tready = 1;
      idle_inputs();
      tick(); tick();
      aresetn = 1;
   endtask

   task automatic test_reset();
      do_reset();
      tick();
      total++; if (m_fb_tvalid !== 1'b0) $display("FAIL reset_tvalid got %b want 0", m_fb_tvalid); else passed++;
      total++; if (m_fb_tdata !== 16'h0) $display("FAIL reset_tdata got %h want 0000", m_fb_tdata); else passed++;
      total++; if ({ack_count_o, nack_count_o, drop_count_o} !== '0) $display("FAIL reset_counts got %h/%h/%h want 0", ack_count_o, nack_count_o, drop_count_o); else passed++;
      $display("test_reset done");
   endtask

   task automatic test_single_ack();
      do_reset();
      s_ack_tdata = 16'h0005; s_ack_tvalid = 1;
      #1;
      total++; if (s_ack_tready !== 1'b1) $display("FAIL single_ready got %b want 1", s_ack_tready); else passed++;
      tick();
      idle_inputs();
      total++; if (m_fb_tvalid !== 1'b1 || m_fb_tdata !== 16'h8005) $display("FAIL single_out got %b/%h want 1/8005", m_fb_tvalid, m_fb_tdata); else passed++;
      total++; if (ack_count_o !== 4'd1) $display("FAIL single_ackcnt got %0d want 1", ack_count_o); else passed++;
      tick();
      total++; if (m_fb_tvalid !== 1'b0) $display("FAIL single_drain got %b want 0", m_fb_tvalid); else passed++;
      $display("test_single_ack done");
   endtask

   task automatic test_alternate();
      logic [15:0] exp_w [4];
      exp_w[0] = 16'h8010; exp_w[1] = 16'h0020; exp_w[2] = 16'h8010; exp_w[3] = 16'h0020;
      do_reset();
      s_ack_tdata = 16'h0010; s_nack_tdata = 16'h0020;
      s_ack_tvalid = 1; s_nack_tvalid = 1;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (i == 3) idle_inputs();
         total++; if (m_fb_tvalid !== 1'b1 || m_fb_tdata !== exp_w[i]) $display("FAIL alt_out[%0d] got %b/%h want 1/%h", i, m_fb_tvalid, m_fb_tdata, exp_w[i]); else passed++;
      end
      total++; if (ack_count_o !== 4'd2 || nack_count_o !== 4'd2 || drop_count_o !== 4'd0) $display("FAIL alt_counts got %0d/%0d/%0d want 2/2/0", ack_count_o, nack_count_o, drop_count_o); else passed++;
      tick();
      $display("test_alternate done");
   endtask

   task automatic test_duplicate();
      do_reset();
      s_ack_tdata = 16'h0123; s_ack_tvalid = 1;
      tick();
      total++; if (m_fb_tdata !== 16'h8123 || m_fb_tvalid !== 1'b1) $display("FAIL dup_first got %b/%h want 1/8123", m_fb_tvalid, m_fb_tdata); else passed++;
      tick();
      s_ack_tvalid = 0;
      total++; if (m_fb_tvalid !== 1'b0) $display("FAIL dup_suppress got tvalid %b want 0", m_fb_tvalid); else passed++;
      total++; if (drop_count_o !== 4'd1 || ack_count_o !== 4'd1) $display("FAIL dup_counts got drop %0d ack %0d want 1 1", drop_count_o, ack_count_o); else passed++;
      s_nack_tdata = 16'h0123; s_nack_tvalid = 1;
      tick();
      idle_inputs();
      total++; if (m_fb_tvalid !== 1'b1 || m_fb_tdata !== 16'h0123 || nack_count_o !== 4'd1) $display("FAIL dup_nack got %b/%h cnt %0d want 1/0123 cnt 1", m_fb_tvalid, m_fb_tdata, nack_count_o); else passed++;
      tick();
      $display("test_duplicate done");
   endtask

   task automatic test_back_to_back();
      logic [15:0] aq [$];
      logic [15:0] nq [$];
      logic [15:0] got [$];
      logic [15:0] exp_w [4];
      bit ahs, nhs;
      exp_w[0] = 16'h80A1; exp_w[1] = 16'h00B1; exp_w[2] = 16'h80A2; exp_w[3] = 16'h00B2;
      do_reset();
      aq = '{16'h00A1, 16'h00A2};
      nq = '{16'h00B1, 16'h00B2};
      for (int cyc = 0; cyc < 30; cyc++) begin
         m_fb_tready   = (cyc >= 6);
         s_ack_tvalid  = (aq.size() > 0);
         s_ack_tdata   = (aq.size() > 0) ? aq[0] : 16'h0;
         s_nack_tvalid = (nq.size() > 0);
         s_nack_tdata  = (nq.size() > 0) ? nq[0] : 16'h0;
         #1;
         if (cyc >= 1 && cyc <= 5) begin
            total++; if (s_ack_tready !== 1'b0 || s_nack_tready !== 1'b0) $display("FAIL bp_ready[%0d] got %b%b want 00", cyc, s_ack_tready, s_nack_tready); else passed++;
            total++; if (m_fb_tvalid !== 1'b1 || m_fb_tdata !== 16'h80A1) $display("FAIL bp_hold[%0d] got %b/%h want 1/80a1", cyc, m_fb_tvalid, m_fb_tdata); else passed++;
         end
         ahs = s_ack_tvalid && s_ack_tready;
         nhs = s_nack_tvalid && s_nack_tready;
         if (m_fb_tvalid && m_fb_tready) got.push_back(m_fb_tdata);
         tick();
         if (ahs) void'(aq.pop_front());
         if (nhs) void'(nq.pop_front());
      end
      idle_inputs();
      m_fb_tready = 1;
      total++; if (got.size() !== 4) $display("FAIL bp_count got %0d want 4", got.size()); else passed++;
      for (int i = 0; i < 4 && i < got.size(); i++) begin
         total++; if (got[i] !== exp_w[i]) $display("FAIL bp_order[%0d] got %h want %h", i, got[i], exp_w[i]); else passed++;
      end
      $display("test_back_to_back done");
   endtask

   task automatic test_closed();
      do_reset();
      s_ack_tdata = 16'h0055; s_ack_tvalid = 1;
      tick();
      idle_inputs();
      tick();
      event_open_i = 0;
      s_ack_tdata = 16'h0055; s_ack_tvalid = 1;
      s_nack_tdata = 16'h0066; s_nack_tvalid = 1;
      for (int i = 0; i < 4; i++) begin
         #1;
         total++; if (s_ack_tready !== 1'b1 || s_nack_tready !== 1'b1) $display("FAIL closed_ready[%0d] got %b%b want 11", i, s_ack_tready, s_nack_tready); else passed++;
         tick();
         total++; if (m_fb_tvalid !== 1'b0) $display("FAIL closed_tvalid[%0d] got %b want 0", i, m_fb_tvalid); else passed++;
      end
      total++; if (ack_count_o !== 4'd1 || nack_count_o !== 4'd0 || drop_count_o !== 4'd0) $display("FAIL closed_counts got %0d/%0d/%0d want 1/0/0", ack_count_o, nack_count_o, drop_count_o); else passed++;
      event_open_i = 1;
      s_nack_tvalid = 0;
      tick();
      idle_inputs();
      total++; if (m_fb_tvalid !== 1'b1 || m_fb_tdata !== 16'h8055 || drop_count_o !== 4'd0) $display("FAIL reopen got %b/%h drop %0d want 1/8055 drop 0", m_fb_tvalid, m_fb_tdata, drop_count_o); else passed++;
      tick();
      $display("test_closed done");
   endtask

   task automatic test_saturation();
      do_reset();
      s_ack_tvalid = 1;
      for (int i = 0; i < 20; i++) begin
         s_ack_tdata = 16'(i);
         tick();
      end
      for (int i = 0; i < 20; i++) tick();
      s_ack_tvalid = 0;
      total++; if (ack_count_o !== 4'hF) $display("FAIL sat_ack got %h want f", ack_count_o); else passed++;
      total++; if (drop_count_o !== 4'hF) $display("FAIL sat_drop got %h want f", drop_count_o); else passed++;
      m_fb_tready = 0;
      s_nack_tdata = 16'h0777; s_nack_tvalid = 1;
      tick();
      s_nack_tvalid = 0;
      total++; if (m_fb_tvalid !== 1'b1 || m_fb_tdata !== 16'h0777) $display("FAIL midrst_pre got %b/%h want 1/0777", m_fb_tvalid, m_fb_tdata); else passed++;
      aresetn = 0;
      tick();
      aresetn = 1;
      total++; if (m_fb_tvalid !== 1'b0) $display("FAIL midrst_tvalid got %b want 0", m_fb_tvalid); else passed++;
      total++; if ({ack_count_o, nack_count_o, drop_count_o} !== '0) $display("FAIL midrst_counts got %h/%h/%h want 0", ack_count_o, nack_count_o, drop_count_o); else passed++;
      m_fb_tready = 1;
      $display("test_saturation done");
   endtask

   task automatic test_random();
      bit ea, en;
      do_reset();
      for (int cyc = 0; cyc < 600; cyc++) begin
         aresetn       = ($urandom_range(0, 99) != 0);
         event_open_i  = ($urandom_range(0, 9) != 0);
         m_fb_tready   = ($urandom_range(0, 9) < 7);
         s_ack_tvalid  = ($urandom_range(0, 9) < 6);
         s_nack_tvalid = ($urandom_range(0, 9) < 6);
         s_ack_tdata   = 16'($urandom_range(0, 3)) | ($urandom_range(0, 1) ? 16'h8000 : 16'h0) | ($urandom_range(0, 1) ? 16'h4000 : 16'h0);
         s_nack_tdata  = 16'($urandom_range(0, 3)) | ($urandom_range(0, 1) ? 16'h8000 : 16'h0);
         #1;
         if (aresetn) begin
            ea = !event_open_i || (pick() == 0 && exp_load());
            en = !event_open_i || (pick() == 1 && exp_load());
            total++; if (s_ack_tready !== ea || s_nack_tready !== en) $display("FAIL rnd_ready[%0d] got %b%b want %b%b", cyc, s_ack_tready, s_nack_tready, ea, en); else passed++;
         end
         tick();
         total++; if (m_fb_tvalid !== m_mv) $display("FAIL rnd_tvalid[%0d] got %b want %b", cyc, m_fb_tvalid, m_mv); else passed++;
         if (m_mv) begin
            total++; if (m_fb_tdata !== m_md) $display("FAIL rnd_tdata[%0d] got %h want %h", cyc, m_fb_tdata, m_md); else passed++;
         end
         total++; if (int'(ack_count_o) !== m_ack || int'(nack_count_o) !== m_nack || int'(drop_count_o) !== m_drop)
            $display("FAIL rnd_counts[%0d] got %0d/%0d/%0d want %0d/%0d/%0d", cyc, ack_count_o, nack_count_o, drop_count_o, m_ack, m_nack, m_drop);
         else passed++;
      end
      aresetn = 1;
      $display("test_random done");
   endtask

   initial begin
      aresetn = 0; event_open_i = 1; m_fb_tready = 1;
      idle_inputs();
      test_reset();
      test_single_ack();
      test_alternate();
      test_duplicate();
      test_back_to_back();
      test_closed();
      test_saturation();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/turf_acknack_merge.md
Name: turf_acknack_merge

Overview:
Sits directly downstream of the two acknack ports (ACK instance and NACK instance) and upstream of the frame buffer's acknack input. Merges the two 16-bit acknack streams into one registered stream with round-robin fairness. Forces the allow bit according to the source, suppresses back-to-back duplicate commands, and keeps per-source statistics counters. Discards all traffic while no event is open.

Parameters:
ADDR_BITS, 12, width of the fragment address field at tdata[ADDR_BITS-1:0]; legal range 1..15.
CNT_BITS, 32, width of the ack and nack statistics counters.
DROP_BITS, 16, width of the drop counter.

Ports:
aclk  input  1  clock
aresetn  input  1  synchronous reset, active-low
event_open_i  input  1  event open; low = drain and discard inputs
s_ack_tdata  input  16  from the ACK port; [ADDR_BITS-1:0] addr, other bits ignored
s_ack_tvalid  input  1  AXI4S valid
s_ack_tready  output  1  AXI4S ready
s_nack_tdata  input  16  from the NACK port; same format
s_nack_tvalid  input  1  AXI4S valid
s_nack_tready  output  1  AXI4S ready
m_fb_tdata  output  16  to the frame buffer; [15] allow, [ADDR_BITS-1:0] addr, all other bits 0
m_fb_tvalid  output  1  AXI4S valid
m_fb_tready  input  1  AXI4S ready
ack_count_o  output  CNT_BITS  ACK commands forwarded, saturating
nack_count_o  output  CNT_BITS  NACK commands forwarded, saturating
drop_count_o  output  DROP_BITS  duplicates suppressed, saturating

Behaviour:
- Reset: aresetn is synchronous, active-low, clock aclk. On reset: m_fb_tvalid=0, m_fb_tdata=0, all counters=0, last_grant=NACK (so ACK wins the first tie), last_fwd_valid=0.
- Output register: a single registered stage. `load = !m_fb_tvalid || m_fb_tready`.
- While m_fb_tvalid=1, m_fb_tdata must stay stable until m_fb_tready.
- Arbitration, evaluated each cycle when event_open_i=1:
  - Only ACK valid: grant ACK.
  - Only NACK valid: grant NACK.
  - Both valid: grant the source that is not last_grant.
  - The granted source's tready = load; the other source's tready = 0.
  - last_grant updates only on an accepted transfer.
- Formatting of an accepted word w:
  - allow = 1 for ACK, 0 for NACK; the input bit 15 is ignored.
  - out = {allow, zeros, w[ADDR_BITS-1:0]}.
- Duplicate filter:
  - If last_fwd_valid and out equals the last forwarded word, the input is still consumed.
  - m_fb_tvalid is not set by that word (an already-pending word stays pending).
  - drop_count increments.
  - Otherwise the output register loads out, m_fb_tvalid=1, last_fwd<=out, last_fwd_valid<=1, and the matching counter increments.
  - The comparison uses the word being loaded, independent of whether the previous word has left yet.
- Latency: an accepted word appears on m_fb one cycle after acceptance. Throughput is one word per cycle with m_fb_tready held high.
- event_open_i=0:
  - Both s_*_tready=1; inputs are consumed and discarded, not counted.
  - last_fwd_valid<=0.
  - A word already in the output register is still delivered normally.
  - last_grant is unchanged.
- event_open_i rising: normal operation on the same cycle; the first word is never treated as a duplicate.
- Counters saturate at all-ones and do not wrap.
- Reset mid-transfer: the pending output word is discarded, m_fb_tvalid=0 on the next cycle. No handshake memory is kept.
- Simultaneous acceptance and output drain in one cycle is legal and required; there are no bubbles.

Test Plan:
1. open=1, ACK addr 0x005, m_fb_tready=1 -> next cycle m_fb_tdata=0x8005, tvalid=1; ack_count=1.
2. ACK 0x010 and NACK 0x020 valid continuously for 4 cycles after reset, ready=1 -> outputs 0x8010, 0x0020, 0x8010(dup? no: separated) alternating ACK/NACK; ack_count=2, nack_count=2, drop_count=0.
3. ACK 0x123 sent twice consecutively (NACK idle) -> one output 0x8123; drop_count=1; then NACK 0x123 -> 0x0123 forwarded (allow differs, not a duplicate).
4. m_fb_tready=0 for 5 cycles with both sources valid -> one word held stable in the output register, both s_*_tready=0 after the first load; release ready -> remaining words delivered in round-robin order with no loss.
5. open=0 with ACK input bit 15=0 and NACK traffic -> all inputs ready, no m_fb_tvalid, counters unchanged; reopen, resend the previous last address -> forwarded, not dropped.
6. Preload ack_count to saturation (force/long run with CNT_BITS=4) -> holds at 0xF; assert aresetn=0 while m_fb_tvalid=1 -> tvalid=0 and counters 0 the next cycle.
